// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the EX-stage data SRAM responder.
// The stall bus layout mirrors the core's pipeline stall vector (bit 2 = EX, bit 3 = MEM).
package data_sram_responder_pkg;

  localparam int STALL_W  = 6;
  localparam int STALL_EX = 2;
  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } rsp_state_e;

  // True when the EX stage is allowed to advance this cycle.
  function automatic logic ex_go(input logic [STALL_W-1:0] stall);
    return (stall[STALL_EX] == NOSTOP);
  endfunction

endpackage

// File: rtl/data_sram_responder_bank.sv
// Word-organised data array with byte-lane writes and a registered
// read-before-write port; the array itself is never cleared.
module dsram_bank
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_access,
  input  logic [3:0]        i_wen,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] r_rdata;

  // Byte-lane writes on the access edge.
  always_ff @(posedge clk) begin
    if (i_access) begin
      for (int i = 0; i < 4; i++) begin
        if (i_wen[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read port returns the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'h0000_0000;
    end else if (i_access) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder for the EX-stage data SRAM interface: latency FSM,
// stall request to CTRL and a single dsram_bank instance.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               data_sram_en,
  input  logic [3:0]         data_sram_wen,
  input  logic [31:0]        data_sram_addr,
  input  logic [31:0]        data_sram_wdata,
  output logic [31:0]        data_sram_rdata,
  output logic               stallreq
);

  localparam int               CNT_W    = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  rsp_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_ex_go;
  logic             w_access;
  logic             w_stallreq;
  logic             w_unused_bits;

  assign w_ex_go = ex_go(stall);

  // Only bit 2 of the stall bus and the word-index bits of addr matter here.
  assign w_unused_bits = ^{stall[STALL_W-1:STALL_EX+1], stall[STALL_EX-1:0],
                           data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  // Access strobe and stall request; stallreq deliberately ignores stall.
  always_comb begin
    w_access   = 1'b0;
    w_stallreq = 1'b0;
    if (LATENCY == 1) begin
      w_access   = data_sram_en && w_ex_go;
      w_stallreq = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_access   = 1'b0;
          w_stallreq = data_sram_en;
        end
        ST_WAIT: begin
          w_access   = data_sram_en && (r_cnt == CNT_ONE) && w_ex_go;
          w_stallreq = (r_cnt > CNT_ONE);
        end
        default: begin
          w_access   = 1'b0;
          w_stallreq = 1'b0;
        end
      endcase
    end
  end

  // Latency FSM; the request fields are used live on the access edge, not captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
    end else if (LATENCY == 1) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (data_sram_en) begin
            r_state <= ST_WAIT;
            r_cnt   <= CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (!data_sram_en) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt > CNT_ONE) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (w_ex_go) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  dsram_bank #(
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .i_access (w_access),
    .i_wen    (data_sram_wen),
    .i_addr   (data_sram_addr[ADDR_W+1:2]),
    .i_wdata  (data_sram_wdata),
    .o_rdata  (data_sram_rdata)
  );

  assign stallreq = w_stallreq;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: table-driven vectors on a LATENCY=1 instance and
// hand-written multi-cycle sequences on a LATENCY=3 instance.
module tb_data_sram_responder;
  import data_sram_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [5:0]  l1_stall = 6'h00, l3_stall = 6'h00;
  logic        l1_en = 1'b0, l3_en = 1'b0;
  logic [3:0]  l1_wen = 4'h0, l3_wen = 4'h0;
  logic [31:0] l1_addr = 32'h0, l3_addr = 32'h0;
  logic [31:0] l1_wdata = 32'h0, l3_wdata = 32'h0;
  logic [31:0] l1_rdata, l3_rdata;
  logic        l1_sr, l3_sr;

  int n_checks = 0;
  int n_errors = 0;

  data_sram_responder #(.ADDR_W(10), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .stall(l1_stall),
    .data_sram_en(l1_en), .data_sram_wen(l1_wen), .data_sram_addr(l1_addr),
    .data_sram_wdata(l1_wdata), .data_sram_rdata(l1_rdata), .stallreq(l1_sr)
  );

  data_sram_responder #(.ADDR_W(10), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .stall(l3_stall),
    .data_sram_en(l3_en), .data_sram_wen(l3_wen), .data_sram_addr(l3_addr),
    .data_sram_wdata(l3_wdata), .data_sram_rdata(l3_rdata), .stallreq(l3_sr)
  );

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [5:0]  stall;
    logic        chk;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // One LATENCY=3 cycle: drive, check stallreq mid-cycle, then optionally rdata after the edge.
  task automatic step3(input string nm, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [5:0] st,
                       input logic exp_sr, input logic chk, input logic [31:0] exp_rd);
    l3_en = en; l3_wen = wen; l3_addr = addr; l3_wdata = wd; l3_stall = st;
    #1;
    check1({nm, "_stallreq"}, l3_sr, exp_sr);
    @(posedge clk); #1;
    if (chk) check32({nm, "_rdata"}, l3_rdata, exp_rd);
  endtask

  // Full three-cycle LATENCY=3 request with no external stall.
  task automatic req3(input string nm, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wd, input logic chk, input logic [31:0] exp_rd);
    step3({nm, "_c0"}, 1'b1, wen, addr, wd, 6'h00, 1'b1, 1'b0, 32'h0);
    step3({nm, "_c1"}, 1'b1, wen, addr, wd, 6'h00, 1'b1, 1'b0, 32'h0);
    step3({nm, "_c2"}, 1'b1, wen, addr, wd, 6'h00, 1'b0, chk, exp_rd);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 6'h00, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         6'h00, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 6'h00, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD, 6'h00, 1'b1, 32'h1122_3344};
    vecs[4]  = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,         6'h00, 1'b1, 32'h11BB_33DD};
    vecs[5]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         6'h00, 1'b1, 32'h11BB_33DD};
    vecs[6]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         6'h3F, 1'b1, 32'h11BB_33DD};
    vecs[7]  = '{1'b1, 4'hF, 32'h0000_1000, 32'hCAFE_F00D, 6'h00, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,         6'h00, 1'b1, 32'hCAFE_F00D};
    vecs[9]  = '{1'b1, 4'h0, 32'h0000_0013, 32'h0,         6'h00, 1'b1, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 4'hF, 32'h0000_0020, 32'h0BAD_0BAD, 6'b000100, 1'b1, 32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,         6'h00, 1'b1, 32'h11BB_33DD};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check32("rst_lat1_rdata", l1_rdata, 32'h0);
    check32("rst_lat3_rdata", l3_rdata, 32'h0);
    check1("rst_lat1_stallreq", l1_sr, 1'b0);
    check1("rst_lat3_stallreq", l3_sr, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      l1_en = vecs[i].en; l1_wen = vecs[i].wen; l1_addr = vecs[i].addr;
      l1_wdata = vecs[i].wdata; l1_stall = vecs[i].stall;
      #1;
      check1($sformatf("lat1_v%0d_stallreq", i), l1_sr, 1'b0);
      @(posedge clk); #1;
      if (vecs[i].chk) check32($sformatf("lat1_v%0d_rdata", i), l1_rdata, vecs[i].exp_rd);
    end
    l1_en = 1'b0; l1_stall = 6'h00;

    req3("pre40", 4'hF, 32'h0000_0040, 32'h0000_0055, 1'b0, 32'h0);
    req3("pre44", 4'hF, 32'h0000_0044, 32'h0000_0066, 1'b0, 32'h0);
    req3("rd40", 4'h0, 32'h0000_0040, 32'h0, 1'b1, 32'h0000_0055);
    step3("b2b_c0", 1'b1, 4'h0, 32'h0000_0044, 32'h0, 6'h00, 1'b1, 1'b1, 32'h0000_0055);
    step3("b2b_c1", 1'b1, 4'h0, 32'h0000_0044, 32'h0, 6'h00, 1'b1, 1'b1, 32'h0000_0055);
    step3("b2b_c2", 1'b1, 4'h0, 32'h0000_0044, 32'h0, 6'h00, 1'b0, 1'b1, 32'h0000_0066);

    step3("xs_c0", 1'b1, 4'h0, 32'h0000_0040, 32'h0, 6'h00, 1'b1, 1'b0, 32'h0);
    step3("xs_c1", 1'b1, 4'h0, 32'h0000_0040, 32'h0, 6'h00, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step3($sformatf("xs_hold%0d", k), 1'b1, 4'h0, 32'h0000_0040, 32'h0, 6'b001100,
            1'b0, 1'b1, 32'h0000_0066);
    end
    step3("xs_rel", 1'b1, 4'h0, 32'h0000_0040, 32'h0, 6'h00, 1'b0, 1'b1, 32'h0000_0055);
    step3("xs_after", 1'b1, 4'h0, 32'h0000_0044, 32'h0, 6'h00, 1'b1, 1'b1, 32'h0000_0055);
    step3("xs_flush", 1'b0, 4'h0, 32'h0000_0044, 32'h0, 6'h00, 1'b1, 1'b1, 32'h0000_0055);

    step3("ab_c0", 1'b1, 4'hF, 32'h0000_0040, 32'h0000_0BAD, 6'h00, 1'b1, 1'b0, 32'h0);
    step3("ab_c1", 1'b0, 4'hF, 32'h0000_0040, 32'h0000_0BAD, 6'h00, 1'b1, 1'b1, 32'h0000_0055);
    step3("ab_c2", 1'b0, 4'hF, 32'h0000_0040, 32'h0000_0BAD, 6'h00, 1'b0, 1'b1, 32'h0000_0055);
    req3("ab_verify", 4'h0, 32'h0000_0040, 32'h0, 1'b1, 32'h0000_0055);

    req3("wrap_wr", 4'hF, 32'h0000_1000, 32'h0000_0077, 1'b0, 32'h0);
    req3("wrap_rd", 4'h0, 32'h0000_0000, 32'h0, 1'b1, 32'h0000_0077);

    step3("rw_c0", 1'b1, 4'hF, 32'h0000_0040, 32'h0000_0099, 6'h00, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check32("rw_rst_lat3_rdata", l3_rdata, 32'h0);
    check32("rw_rst_lat1_rdata", l1_rdata, 32'h0);
    step3("rw_idle", 1'b0, 4'h0, 32'h0000_0040, 32'h0, 6'h00, 1'b0, 1'b1, 32'h0);
    req3("rw_verify", 4'h0, 32'h0000_0040, 32'h0, 1'b1, 32'h0000_0055);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder (memory side) for the EX-stage data SRAM request interface: en, 4-bit byte-lane wen, addr, wdata.
- Holds a word-organised data array and performs byte-lane writes and reads with a configurable access latency.
- For latency >1, raises a stall request to CTRL so EX holds its request.
- Returns read data registered, aligned with the MEM stage.

Parameters:
- ADDR_W, 10, word-address width; array depth = 2**ADDR_W words.
- LATENCY, 1, access latency in cycles, minimum 1; the pipeline stalls for LATENCY-1 cycles per request.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  `StallBus  pipeline stall vector from CTRL; bit 2 = EX stage.
- data_sram_en  in  1  request valid.
- data_sram_wen  in  4  byte-lane write enable; 0 = read.
- data_sram_addr  in  32  byte address; word index = addr[ADDR_W+1:2].
- data_sram_wdata  in  32  write data, already lane-aligned by EX.
- data_sram_rdata  out  32  registered read data.
- stallreq  out  1  stall request to CTRL.

Behaviour:
- Reset: state IDLE, cnt=0, data_sram_rdata=0, stallreq=0. The array is not cleared. Reset mid-WAIT abandons the request; no write occurs.
- Addressing: addr[1:0] and addr[31:ADDR_W+2] are ignored, so addresses wrap modulo the array size.
- Access edge: the single clock edge at which the array is read and/or written.
  - Lane i is written with wdata[8i+7:8i] when wen[i]=1.
  - data_sram_rdata loads the pre-write word (read-before-write), on reads and on writes.
  - data_sram_rdata changes only on access edges; otherwise it holds.
- States: IDLE, WAIT; cnt is a counter of width clog2(LATENCY)+1.
- LATENCY=1:
  - FSM never leaves IDLE; stallreq is constant 0.
  - An access edge occurs at the end of any cycle with en=1 and stall[2]==`NoStop.
  - Read data is therefore valid exactly one cycle after the request, while the instruction is in MEM.
- LATENCY>1, IDLE:
  - en=1 -> stallreq=1 combinationally that cycle; at the edge go to WAIT with cnt=LATENCY-1.
  - No access occurs at that edge, whatever the value of stall.
- WAIT:
  - stallreq = (cnt>1). At each edge with cnt>1, cnt decrements.
  - When cnt==1 and stall[2]==`NoStop: access edge, then IDLE.
  - When cnt==1 and stall[2]==`Stop (stall from another source): remain in WAIT with cnt=1 and stallreq=0 until stall[2] releases.
- Stall count: total self-stall is exactly LATENCY-1 cycles per request.
- EX request stability: EX holds addr/wen/wdata stable while stalled; the responder does not re-capture them in WAIT and uses live inputs on the access edge.
- Abort: en=0 in WAIT (request flushed) -> IDLE at the next edge; no access, rdata unchanged.
- Bubble case: stall[2]==`Stop with stall[3]==`NoStop -> EX is frozen, no access edge.
- Back-to-back: after the access edge the FSM is IDLE. A new request in the next cycle restarts the sequence with stallreq=1 immediately.
- Combinational path: stallreq depends combinationally on data_sram_en, state and cnt only, never on stall (avoids a loop through CTRL).

Decomposition:
- `StallBus, `Stop and `NoStop come from lib/defines.vh; no new shared constants are needed.
- Sub-module dsram_bank: 2**ADDR_W x 32 array, 4 byte write enables, synchronous read-before-write port with an access enable. It is instantiated once.
- FSM, counter and stall logic live in data_sram_responder.

Test Plan:
- LAT=1: write addr 0x10, wen=4'b1111, wdata 0xDEADBEEF; next cycle read 0x10 -> rdata=0xDEADBEEF one cycle after the read request; stallreq stays 0.
- LAT=1 byte lanes: word 0x20 holds 0x11223344; write wen=4'b0101, wdata 0xAABBCCDD; read -> 0x11BB33DD. The write cycle itself returns rdata=0x11223344.
- LAT=3, read 0x40 (holds 0x55): stallreq high exactly 2 cycles (request cycle + 1). rdata=0x55 appears the cycle after stallreq falls. Back-to-back second read re-asserts stallreq immediately.
- LAT=3 external stall: hold stall[2]=Stop for 4 cycles while cnt==1 -> no access, stallreq=0. Release -> single access, rdata updates once.
- Abort and wrap (ADDR_W=10): drop en during WAIT on a write -> memory is unchanged. Write 0x1000 then read 0x0000 (wrap) -> same word.
- Reset mid-WAIT: assert rst -> stallreq=0, rdata=0, state IDLE; the pending write is not performed.
